rf_mp: RTL and testbench
========================

Name: rf_mp

Overview:
- Parametrised multi-read-port integer register file; successor to the single-config 2R1W file.
- Sits between decode (read ports, issue scoreboard) and writeback (write port) in the core.
- Adds per-register busy scoreboard for multi-cycle ops and post-reset clear sweep, so the array carries no reset and can infer as RAM.

Parameters:
- XLEN, 32, data word width.
- NREGS, 32, architectural registers (16 for RV32E); 2..32.
- NRPORTS, 2, number of combinational read ports; 1..4.
- RIDW, 5, register-index width on all ports (ISA encoding width, fixed by package).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ready  out  1  high once clear sweep complete.
- wen  in  1  writeback enable.
- rd  in  RIDW  writeback index.
- wdata  in  XLEN  writeback data.
- rs  in  NRPORTS*RIDW  read indices, port p at [p*RIDW +: RIDW].
- rdata  out  NRPORTS*XLEN  read data, port p at [p*XLEN +: XLEN].
- rs_busy  out  NRPORTS  scoreboard busy bit of each rs.
- issue_valid  in  1  mark issue_rd pending.
- issue_rd  in  RIDW  destination of issued multi-cycle op.

Behaviour:
- Reset (reset_n low, async): FSM -> CLEAR, sweep index 0, busy vector all 0, ready 0. Array not reset.
- FSM CLEAR: writes 0 to reg[sweep] each cycle, sweep++; after writing NREGS-1 -> READY next cycle (ready high exactly NREGS cycles after reset_n rises). READY is terminal until next reset.
- While !ready: rdata all 0, rs_busy all 0, wen and issue_valid ignored.
- Reset asserted mid-sweep: sweep restarts from 0.
- Reads: combinational, zero latency. Index 0 or index >= NREGS -> rdata 0, rs_busy 0.
- Write: wen && rd != 0 && rd < NREGS -> reg[rd] <= wdata on posedge; otherwise ignored. Visible on rdata the following cycle (see bypass).
- Scoreboard: issue_valid with valid nonzero issue_rd sets busy[issue_rd]; accepted write clears busy[rd]. Same index set and clear in one cycle: set wins (new issue after older writeback). Different indices: both take effect. busy[0] constantly 0.
- rs_busy[p] = busy[rs[p]] registered state only (no same-cycle issue forwarding).
- Writes do not require busy set; write to non-busy reg is legal.
- Out-of-range index arithmetic: compare on full RIDW before truncating to array address.

Optional Feature:
- RF_BYPASS_EN defined: if accepted write rd == rs[p] (nonzero, in range), rdata[p] = wdata same cycle and rs_busy[p] = 0 same cycle (unless issue sets same reg — rs_busy still reflects registered state only, so forwarded clear applies).
- Undefined: rdata returns old array value during the write cycle; rs_busy clears the cycle after.

Decomposition:
- Shared package rf_pkg: RIDW, XLEN default, NREGS_I/NREGS_E constants, rf_state_t enum {RF_CLEAR, RF_READY}.
- Sub-module rf_scoreboard (busy vector, set/clear priority, NRPORTS lookups); array, sweep FSM and read muxes stay in rf_mp.

Test Plan:
- Release reset_n, NREGS=32 -> ready low 32 cycles, high cycle 32; all rs reads 0; wen with rd=5 during sweep leaves x5=0.
- Write rd=7 wdata=0xDEADBEEF, rs[0]=7 same cycle -> old 0 (bypass off) / 0xDEADBEEF (bypass on); next cycle 0xDEADBEEF on both ports.
- Write rd=0 wdata=0x1234 and rd=20 with NREGS=16 -> reads of 0 and 20 return 0; x4 unaffected.
- issue_rd=3, later wen rd=3 -> rs_busy for rs=3 high between, low after write; simultaneous issue_rd=3 and wen rd=3 -> busy remains 1.
- NRPORTS=4, rs={1,2,3,1} after writing 0x11,0x22,0x33 -> rdata {0x11,0x22,0x33,0x11}.
- Pulse reset_n low mid-operation with x9 busy -> busy cleared, ready low, full sweep repeats, x9 reads 0 after ready.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port integer register file: the ISA
// register-index width, default word width, register-count presets, the
// sweep FSM state type and the index range check used on every port.
package rf_pkg;

    localparam int RIDW     = 5;   // register-index width, fixed by the ISA encoding
    localparam int XLEN_DEF = 32;  // default data word width
    localparam int NREGS_I  = 32;  // full integer register set
    localparam int NREGS_E  = 16;  // reduced register set (RV32E)

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

    // True when idx names a real, writable register. The comparison is done
    // on the full index width so an out-of-range index can never alias onto a
    // low register once it is truncated to an array address.
    function automatic logic rf_idx_ok(input logic [RIDW-1:0] idx, input int nregs);
        return (idx != '0) && ({1'b0, idx} < (RIDW+1)'(nregs));
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard. An issued multi-cycle op marks its
// destination busy; the matching writeback clears it. When the same index is
// set and cleared in one cycle the set wins, because the issue is younger
// than the writeback. Register 0 is never busy. Lookups return the registered
// state only. The caller qualifies set_en/clr_en (ready, index range).
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS   = NREGS_I,
    parameter int NRPORTS = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    set_en,
    input  logic [RIDW-1:0]         set_idx,
    input  logic                    clr_en,
    input  logic [RIDW-1:0]         clr_idx,
    input  logic [NRPORTS*RIDW-1:0] rs,
    output logic [NRPORTS-1:0]      busy
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Next busy vector: clear first, then set, so a same-index set wins
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        w_busy_nxt = r_busy;
        if (clr_en) begin
            w_busy_nxt[clr_idx[AW-1:0]] = 1'b0;
        end
        if (set_en) begin
            w_busy_nxt[set_idx[AW-1:0]] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Busy state register, cleared by reset
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Read-port lookups against registered state; out-of-range reads are not busy
    always_comb begin
        busy = '0;
        for (int p = 0; p < NRPORTS; p++) begin
            if (rf_idx_ok(rs[p*RIDW +: RIDW], NREGS)) begin
                busy[p] = r_busy[rs[p*RIDW+AW-1 -: AW]];
            end
        end
    end

endmodule

// File: rtl/rf_mp.sv
// Parametrised multi-read-port integer register file with a per-register
// busy scoreboard. After reset a clear sweep writes zero to every register,
// one per cycle, so the storage array itself carries no reset and can map
// onto RAM. Reads are combinational; the single write port is shared between
// the sweep and writeback.
// Optional build macro: RF_BYPASS_EN forwards an accepted write to any read
// port naming the same register in the same cycle (data and busy clear).
module rf_mp
    import rf_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREGS   = NREGS_I,
    parameter int NRPORTS = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    output logic                    ready,
    input  logic                    wen,
    input  logic [RIDW-1:0]         rd,
    input  logic [XLEN-1:0]         wdata,
    input  logic [NRPORTS*RIDW-1:0] rs,
    output logic [NRPORTS*XLEN-1:0] rdata,
    output logic [NRPORTS-1:0]      rs_busy,
    input  logic                    issue_valid,
    input  logic [RIDW-1:0]         issue_rd
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    rf_state_t         r_state;
    rf_state_t         w_state_nxt;
    logic [AW-1:0]     r_sweep;
    logic              w_sweep_we;
    logic              w_sweep_last;

    logic [XLEN-1:0]   r_mem [NREGS];
    logic              w_mem_we;
    logic [AW-1:0]     w_mem_addr;
    logic [XLEN-1:0]   w_mem_data;

    logic              w_wr_ok;
    logic              w_issue_ok;
    logic [RIDW-1:0]   w_rs_idx [NRPORTS];
    logic [NRPORTS-1:0] w_rs_ok;
    logic [NRPORTS-1:0] w_byp_hit;
    logic [NRPORTS-1:0] w_sb_busy;

    assign w_sweep_last = (r_sweep == AW'(NREGS - 1));

    // Writeback and issue only count once the sweep is done and the index is real
    assign w_wr_ok    = ready && wen && rf_idx_ok(rd, NREGS);
    assign w_issue_ok = ready && issue_valid && rf_idx_ok(issue_rd, NREGS);

    // Sweep FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RF_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sweep FSM next state: leave CLEAR on the cycle the last register is written
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RF_CLEAR: if (w_sweep_last) w_state_nxt = RF_READY;
            RF_READY: w_state_nxt = RF_READY;
            default:  w_state_nxt = RF_CLEAR;
        endcase
    end

    // Sweep FSM outputs
    always_comb begin
        ready      = (r_state == RF_READY);
        w_sweep_we = (r_state == RF_CLEAR);
    end

    // Sweep index: restarts from zero on every reset, stops at the last register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sweep <= '0;
        end else if (w_sweep_we && !w_sweep_last) begin
            r_sweep <= r_sweep + 1'b1;
        end
    end

    // Single write port shared by the clear sweep and writeback
    always_comb begin
        w_mem_we   = w_sweep_we || w_wr_ok;
        w_mem_addr = w_sweep_we ? r_sweep : rd[AW-1:0];
        w_mem_data = w_sweep_we ? '0 : wdata;
    end

    // Register array write
    always_ff @(posedge clock) begin
        // NOTE: the array has no reset on purpose; the post-reset sweep zeroes it so it can infer as RAM.
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    for (genvar p = 0; p < NRPORTS; p++) begin : g_port
        assign w_rs_idx[p] = rs[p*RIDW +: RIDW];
        assign w_rs_ok[p]  = ready && rf_idx_ok(w_rs_idx[p], NREGS);
`ifdef RF_BYPASS_EN
        assign w_byp_hit[p] = w_wr_ok && (rd == w_rs_idx[p]);
`else
        assign w_byp_hit[p] = 1'b0;
`endif
    end

    // Read ports: zero-latency mux, zero for register 0, out-of-range or not ready
    always_comb begin
        rdata = '0;
        for (int p = 0; p < NRPORTS; p++) begin
            if (w_rs_ok[p]) begin
                rdata[p*XLEN +: XLEN] = w_byp_hit[p] ? wdata : r_mem[w_rs_idx[p][AW-1:0]];
            end
        end
    end

    rf_scoreboard #(
        .NREGS   (NREGS),
        .NRPORTS (NRPORTS)
    ) u_scoreboard (
        .clock   (clock),
        .reset_n (reset_n),
        .set_en  (w_issue_ok),
        .set_idx (issue_rd),
        .clr_en  (w_wr_ok),
        .clr_idx (rd),
        .rs      (rs),
        .busy    (w_sb_busy)
    );

    // A forwarded write also clears the busy bit seen by the reader this cycle
    assign rs_busy = w_sb_busy & w_rs_ok & ~w_byp_hit;

endmodule

// File: tb/tb_rf_mp.sv
// Bench for rf_mp: two instances (32 and 16 registers, four read ports) share
// one directed stimulus stream. A reference model derived from the register
// file's behavioural rules is compared against both instances every cycle,
// and a set of hand-computed literal checks pins the model.
module tb_rf_mp;
    import rf_pkg::*;

    localparam int NP = 4;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset_n;
    logic              wen;
    logic [RIDW-1:0]   rd;
    logic [31:0]       wdata;
    logic [NP*RIDW-1:0] rs;
    logic              issue_valid;
    logic [RIDW-1:0]   issue_rd;

    logic              ready_i, ready_e;
    logic [NP*32-1:0]  rdata_i, rdata_e;
    logic [NP-1:0]     busy_i, busy_e;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    rf_mp #(.XLEN(32), .NREGS(32), .NRPORTS(NP)) u_dut_i (
        .clock(clock), .reset_n(reset_n), .ready(ready_i), .wen(wen), .rd(rd),
        .wdata(wdata), .rs(rs), .rdata(rdata_i), .rs_busy(busy_i),
        .issue_valid(issue_valid), .issue_rd(issue_rd)
    );

    rf_mp #(.XLEN(32), .NREGS(16), .NRPORTS(NP)) u_dut_e (
        .clock(clock), .reset_n(reset_n), .ready(ready_e), .wen(wen), .rd(rd),
        .wdata(wdata), .rs(rs), .rdata(rdata_e), .rs_busy(busy_e),
        .issue_valid(issue_valid), .issue_rd(issue_rd)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          cfg_n [2] = '{32, 16};
    logic [31:0] m_mem [2][32];
    bit          m_busy[2][32];
    int          m_cnt [2];     // clock edges seen since reset release

    function automatic bit in_rng(input int c, input logic [4:0] i);
        return (i != 5'd0) && (int'(i) < cfg_n[c]);
    endfunction

    function automatic bit m_ready(input int c);
        return m_cnt[c] >= cfg_n[c];
    endfunction

    // After a completed sweep every register reads zero and nothing is busy
    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_cnt[c] = 0;
            for (int r = 0; r < 32; r++) begin
                m_mem[c][r]  = 32'd0;
                m_busy[c][r] = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < 2; c++) begin
            if (!m_ready(c)) begin
                m_cnt[c]++;
            end else begin
                if (wen && in_rng(c, rd)) begin
                    m_mem[c][rd]  = wdata;
                    m_busy[c][rd] = 1'b0;
                end
                if (issue_valid && in_rng(c, issue_rd)) m_busy[c][issue_rd] = 1'b1;
            end
        end
    endtask

    function automatic bit fwd_hit(input int c, input logic [4:0] i);
        return BYP && wen && in_rng(c, rd) && (rd == i);
    endfunction

    function automatic logic [31:0] m_rdata(input int c, input int p);
        logic [4:0] i;
        i = rs[p*RIDW +: RIDW];
        if (!m_ready(c) || !in_rng(c, i)) return 32'd0;
        if (fwd_hit(c, i)) return wdata;
        return m_mem[c][i];
    endfunction

    function automatic logic m_rbusy(input int c, input int p);
        logic [4:0] i;
        i = rs[p*RIDW +: RIDW];
        if (!m_ready(c) || !in_rng(c, i)) return 1'b0;
        if (fwd_hit(c, i)) return 1'b0;
        return m_busy[c][i];
    endfunction

    // Compare process: outputs at every falling edge, model advances on rising edges
    initial begin
        model_reset();
        forever begin
            @(negedge clock);
            if (!reset_n) model_reset();
            check("mdl_ready_i", {31'd0, ready_i}, {31'd0, m_ready(0)});
            check("mdl_ready_e", {31'd0, ready_e}, {31'd0, m_ready(1)});
            for (int p = 0; p < NP; p++) begin
                check($sformatf("mdl_rdata_i[%0d]", p), rdata_i[p*32 +: 32], m_rdata(0, p));
                check($sformatf("mdl_rdata_e[%0d]", p), rdata_e[p*32 +: 32], m_rdata(1, p));
                check($sformatf("mdl_busy_i[%0d]", p), {31'd0, busy_i[p]}, {31'd0, m_rbusy(0, p)});
                check($sformatf("mdl_busy_e[%0d]", p), {31'd0, busy_e[p]}, {31'd0, m_rbusy(1, p)});
            end
            @(posedge clock);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [NP*RIDW-1:0] pack_rs(input logic [4:0] a, input logic [4:0] b,
                                                   input logic [4:0] c, input logic [4:0] d);
        return {d, c, b, a};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        wen = 1'b0; rd = '0; wdata = '0; issue_valid = 1'b0; issue_rd = '0;
    endtask

    // Runs 33 edges after reset release, checking ready timing for both sizes.
    // With traffic set, writes to x5 and issues to x6 are attempted in the sweep.
    task automatic sweep_wait(input bit traffic);
        if (traffic) begin
            wen = 1'b1; rd = 5'd5; wdata = 32'hAAAA5555;
            issue_valid = 1'b1; issue_rd = 5'd6;
        end
        for (int k = 1; k <= 33; k++) begin
            cyc();
            if (k == 10) idle_inputs();
            if (k == 15) check("ready_e_edge15", {31'd0, ready_e}, 32'd0);
            if (k == 16) check("ready_e_edge16", {31'd0, ready_e}, 32'd1);
            if (k == 31) check("ready_i_edge31", {31'd0, ready_i}, 32'd0);
            if (k == 32) check("ready_i_edge32", {31'd0, ready_i}, 32'd1);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        rs = '0;
        idle_inputs();
        repeat (3) cyc();
        @(negedge clock);
        check("reset_ready_i", {31'd0, ready_i}, 32'd0);
        check("reset_busy_i", {28'd0, busy_i}, 32'd0);

        // Release reset; writes and issues during the sweep must be ignored
        cyc();
        reset_n = 1'b1;
        sweep_wait(1'b1);
        rs = pack_rs(5'd5, 5'd6, 5'd0, 5'd0);
        @(negedge clock);
        check("x5_after_sweep_i", rdata_i[31:0], 32'd0);
        check("x5_after_sweep_e", rdata_e[31:0], 32'd0);
        check("x6_busy_after_sweep", {31'd0, busy_i[1]}, 32'd0);

        // Write x7 while reading it on two ports
        cyc();
        wen = 1'b1; rd = 5'd7; wdata = 32'hDEADBEEF;
        rs = pack_rs(5'd7, 5'd7, 5'd0, 5'd0);
        @(negedge clock);
        check("x7_write_cycle", rdata_i[31:0], BYP ? 32'hDEADBEEF : 32'd0);
        cyc();
        idle_inputs();
        @(negedge clock);
        check("x7_port0", rdata_i[31:0], 32'hDEADBEEF);
        check("x7_port1", rdata_i[63:32], 32'hDEADBEEF);

        // x0 write ignored; x20 is real for 32 regs, out of range (and must not alias x4) for 16
        cyc(); wen = 1'b1; rd = 5'd4;  wdata = 32'h44;
        cyc(); wen = 1'b1; rd = 5'd0;  wdata = 32'h1234;
        cyc(); wen = 1'b1; rd = 5'd20; wdata = 32'h2020;
        cyc();
        idle_inputs();
        rs = pack_rs(5'd0, 5'd20, 5'd4, 5'd0);
        @(negedge clock);
        check("x0_read_i", rdata_i[31:0], 32'd0);
        check("x20_read_i", rdata_i[63:32], 32'h2020);
        check("x20_read_e", rdata_e[63:32], 32'd0);
        check("x4_read_e", rdata_e[95:64], 32'h44);

        // Scoreboard: issue x3, then write back
        cyc();
        issue_valid = 1'b1; issue_rd = 5'd3;
        rs = pack_rs(5'd3, 5'd0, 5'd0, 5'd0);
        @(negedge clock);
        check("x3_busy_issue_cycle", {31'd0, busy_i[0]}, 32'd0);
        cyc();
        idle_inputs();
        @(negedge clock);
        check("x3_busy_pending", {31'd0, busy_i[0]}, 32'd1);
        cyc();
        wen = 1'b1; rd = 5'd3; wdata = 32'h33;
        @(negedge clock);
        check("x3_busy_wb_cycle", {31'd0, busy_i[0]}, BYP ? 32'd0 : 32'd1);
        cyc();
        idle_inputs();
        @(negedge clock);
        check("x3_busy_after_wb", {31'd0, busy_e[0]}, 32'd0);
        // Issue and writeback of x3 together: set wins
        cyc();
        wen = 1'b1; rd = 5'd3; wdata = 32'h33;
        issue_valid = 1'b1; issue_rd = 5'd3;
        cyc();
        idle_inputs();
        @(negedge clock);
        check("x3_busy_set_wins", {31'd0, busy_i[0]}, 32'd1);
        cyc();
        wen = 1'b1; rd = 5'd3; wdata = 32'h33;
        cyc();
        idle_inputs();

        // Four read ports
        cyc(); wen = 1'b1; rd = 5'd1; wdata = 32'h11;
        cyc(); wen = 1'b1; rd = 5'd2; wdata = 32'h22;
        cyc();
        idle_inputs();
        rs = pack_rs(5'd1, 5'd2, 5'd3, 5'd1);
        @(negedge clock);
        check("four_port_i", rdata_i[31:0] ^ rdata_i[63:32] ^ rdata_i[95:64] ^ rdata_i[127:96], 32'h11 ^ 32'h22 ^ 32'h33 ^ 32'h11);
        check("four_port_e0", rdata_e[31:0], 32'h11);
        check("four_port_e1", rdata_e[63:32], 32'h22);
        check("four_port_e2", rdata_e[95:64], 32'h33);
        check("four_port_e3", rdata_e[127:96], 32'h11);

        // Reset mid-operation with x9 busy
        cyc(); wen = 1'b1; rd = 5'd9; wdata = 32'h99;
        cyc();
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd9;
        cyc();
        idle_inputs();
        rs = pack_rs(5'd9, 5'd0, 5'd0, 5'd0);
        @(negedge clock);
        check("x9_before_reset", rdata_i[31:0], 32'h99);
        check("x9_busy_before_reset", {31'd0, busy_i[0]}, 32'd1);
        cyc();
        reset_n = 1'b0;
        @(negedge clock);
        check("midreset_ready", {31'd0, ready_i}, 32'd0);
        check("midreset_busy", {31'd0, busy_i[0]}, 32'd0);
        cyc();
        reset_n = 1'b1;
        sweep_wait(1'b0);
        @(negedge clock);
        check("x9_after_resweep", rdata_i[31:0], 32'd0);
        check("x9_busy_after_resweep", {31'd0, busy_i[0]}, 32'd0);

        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
